// File: rtl/imem_boot_loader_pkg.sv
// ============================================================================
// Module      : boot_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader: loader state encoding, default widths and the width
//               of the optional image checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_pkg;

    // Loader state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    // Default configuration: 256-word memory indexed by PC[9:2]
    localparam int c_def_addr_w    = 8;
    localparam int c_def_max_words = 256;
    localparam int c_def_rst_hold  = 4;

    // Width of the running image checksum
    localparam int c_checksum_w    = 32;

endpackage

`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// Module      : imem_boot_loader_if
// Description : Bus bundle between host, boot loader and instruction memory.
//               Host stream : host_valid, host_data, host_last -> loader,
//                             host_ready <- loader.
//               Memory port : imem_en, imem_addr, imem_data <- loader.
//               master = host/memory side, slave = loader side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
    parameter int ADDR_W = boot_pkg::c_def_addr_w
);
    logic              host_valid;
    logic [31:0]       host_data;
    logic              host_last;
    logic              host_ready;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;

    modport master (
        output host_valid, host_data, host_last,
        input  host_ready, imem_en, imem_addr, imem_data
    );

    modport slave (
        input  host_valid, host_data, host_last,
        output host_ready, imem_en, imem_addr, imem_data
    );
endinterface

`default_nettype wire

// File: rtl/imem_boot_loader_rst_hold_timer.sv
// ============================================================================
// Module      : rst_hold_timer
// Description : Load/count-down timer that stretches core reset after the
//               final image write. i_load presets the count to RST_HOLD-1;
//               while i_en is high the count decrements to zero and stops.
//               o_expired is high whenever the count is zero.
// Ports       : clk, rst (sync, active-high), i_load, i_en, o_expired
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_hold_timer #(
    parameter int RST_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);
    localparam int c_cnt_w = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(RST_HOLD - 1);

    logic [c_cnt_w-1:0] r_count;

    // Preset to RST_HOLD-1 so that, counting the cycle in which the timer is
    // seen at zero, the enabling state lasts exactly RST_HOLD cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Boot sequencer for the single-cycle RV32I core. Streams
//               instruction words from a host into instruction memory at
//               consecutive word addresses from 0, holds the core in reset
//               while loading and for RST_HOLD cycles afterwards, then
//               releases it.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - single-cycle (re)load request
//               bus (slave)     - host stream in, host_ready out,
//                                 imem_en/imem_addr/imem_data out
//               load_active     - loader owns the instruction-memory port
//               cpu_rst         - reset to the core
//               done            - image loaded and core running
//               err             - sticky: capacity reached without host_last
//               word_count      - words accepted in the current load
//               checksum        - mod-2^32 sum of accepted words
//                                 (only with LOAD_CHECKSUM_EN defined)
// Options     : LOAD_CHECKSUM_EN - adds the checksum port and adder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = c_def_addr_w,
    parameter int MAX_WORDS = c_def_max_words,
    parameter int RST_HOLD  = c_def_rst_hold
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    imem_boot_loader_if.slave       bus,
    output logic                    load_active,
    output logic                    cpu_rst,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_W:0]         word_count
`ifdef LOAD_CHECKSUM_EN
    ,
    output logic [c_checksum_w-1:0] checksum
`endif
);
    localparam logic [ADDR_W:0] c_max_words = (ADDR_W + 1)'(MAX_WORDS);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_host_ready;
    logic            w_handshake;
    logic            w_start_load;
    logic            w_overflow;
    logic            w_timer_load;
    logic            w_timer_expired;
    logic [ADDR_W:0] w_count_inc;

    assign w_host_ready   = (r_state == LOAD);
    assign bus.host_ready = w_host_ready;
    assign w_handshake    = bus.host_valid & w_host_ready;
    assign w_count_inc    = word_count + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_start_load = 1'b0;
        w_overflow   = 1'b0;
        w_timer_load = 1'b0;
        case (r_state)
            IDLE, RUN: begin
                if (start) begin
                    w_state_next = LOAD;
                    w_start_load = 1'b1;
                end
            end
            LOAD: begin
                if (w_handshake) begin
                    // host_last wins over the capacity check, so a full
                    // image that ends exactly at capacity is not an error.
                    if (bus.host_last) begin
                        w_state_next = HOLD;
                        w_timer_load = 1'b1;
                    end else if (w_count_inc == c_max_words) begin
                        w_state_next = HOLD;
                        w_timer_load = 1'b1;
                        w_overflow   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (w_timer_expired) begin
                    w_state_next = RUN;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            cpu_rst       <= 1'b1;
            load_active   <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            word_count    <= '0;
            bus.imem_en   <= 1'b0;
            bus.imem_addr <= '0;
            bus.imem_data <= '0;
        end else begin
            r_state     <= w_state_next;
            cpu_rst     <= (w_state_next != RUN);
            done        <= (w_state_next == RUN);
            load_active <= (w_state_next == LOAD) || (w_state_next == HOLD);
            bus.imem_en <= w_handshake;
            if (w_handshake) begin
                bus.imem_addr <= word_count[ADDR_W-1:0];
                bus.imem_data <= bus.host_data;
            end
            if (w_start_load) begin
                word_count <= '0;
                err        <= 1'b0;
            end else begin
                if (w_handshake) begin
                    word_count <= w_count_inc;
                end
                if (w_overflow) begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef LOAD_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || w_start_load) begin
            checksum <= '0;
        end else if (w_handshake) begin
            checksum <= checksum + bus.host_data;
        end
    end
`endif

    rst_hold_timer #(
        .RST_HOLD (RST_HOLD)
    ) u_rst_hold_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_timer_load),
        .i_en      (r_state == HOLD),
        .o_expired (w_timer_expired)
    );

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module      : tb_imem_boot_loader
// Description : Directed self-checking bench for imem_boot_loader
//               (MAX_WORDS=4, RST_HOLD=4). Checksum steps are included when
//               LOAD_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 4;
    localparam int RST_HOLD  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            load_active;
    logic            cpu_rst;
    logic            done;
    logic            err;
    logic [ADDR_W:0] word_count;
`ifdef LOAD_CHECKSUM_EN
    logic [c_checksum_w-1:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_boot_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .load_active (load_active),
        .cpu_rst     (cpu_rst),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
`ifdef LOAD_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Offer one word, wait (bounded) for host_ready, then check the write.
    task automatic send(input logic [31:0] data, input logic last, input logic [ADDR_W-1:0] exp_addr);
        int n = 0;
        bus.host_valid = 1'b1;
        bus.host_data  = data;
        bus.host_last  = last;
        while (bus.host_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("host_ready_before_send", {63'd0, bus.host_ready}, 64'd1);
        tick();
        bus.host_valid = 1'b0;
        bus.host_last  = 1'b0;
        chk("imem_en", {63'd0, bus.imem_en}, 64'd1);
        chk("imem_addr", {56'd0, bus.imem_addr}, {56'd0, exp_addr});
        chk("imem_data", {32'd0, bus.imem_data}, {32'd0, data});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        start          = 1'b0;
        bus.host_valid = 1'b0;
        bus.host_data  = '0;
        bus.host_last  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_load_active", {63'd0, load_active}, 64'd0);
        chk("rst_host_ready", {63'd0, bus.host_ready}, 64'd0);
        chk("rst_imem_en", {63'd0, bus.imem_en}, 64'd0);
        chk("rst_word_count", {55'd0, word_count}, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_host_ready", {63'd0, bus.host_ready}, 64'd0);

        // Basic 3-word load, back-to-back
        pulse_start();
        chk("load_host_ready", {63'd0, bus.host_ready}, 64'd1);
        chk("load_active", {63'd0, load_active}, 64'd1);
        send(32'h0050_0093, 1'b0, 8'd0);
        chk("wc_1", {55'd0, word_count}, 64'd1);
        send(32'h00A0_0113, 1'b0, 8'd1);
        send(32'h0020_81B3, 1'b1, 8'd2);
        chk("wc_3", {55'd0, word_count}, 64'd3);
        chk("hold_host_ready", {63'd0, bus.host_ready}, 64'd0);
        chk("hold_load_active", {63'd0, load_active}, 64'd1);
        repeat (3) tick();
        chk("hold_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("hold_done", {63'd0, done}, 64'd0);
        chk("hold_imem_en", {63'd0, bus.imem_en}, 64'd0);
        tick();
        chk("run_cpu_rst", {63'd0, cpu_rst}, 64'd0);
        chk("run_done", {63'd0, done}, 64'd1);
        chk("run_load_active", {63'd0, load_active}, 64'd0);
        chk("run_err", {63'd0, err}, 64'd0);
        chk("run_wc", {55'd0, word_count}, 64'd3);

        // Throttled host: 2-cycle gaps between words
        pulse_start();
        chk("restart_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("restart_done", {63'd0, done}, 64'd0);
        chk("restart_wc", {55'd0, word_count}, 64'd0);
        send(32'h1111_1111, 1'b0, 8'd0);
        tick();
        chk("gap1_imem_en", {63'd0, bus.imem_en}, 64'd0);
        tick();
        chk("gap2_imem_en", {63'd0, bus.imem_en}, 64'd0);
        send(32'h2222_2222, 1'b0, 8'd1);
        tick();
        chk("gap3_imem_en", {63'd0, bus.imem_en}, 64'd0);
        tick();
        send(32'h3333_3333, 1'b1, 8'd2);
        repeat (4) tick();
        chk("throttle_done", {63'd0, done}, 64'd1);

        // Overflow at capacity; start during LOAD is ignored
        pulse_start();
        send(32'hA000_0000, 1'b0, 8'd0);
        send(32'hA000_0001, 1'b0, 8'd1);
        pulse_start();
        chk("start_ignored_wc", {55'd0, word_count}, 64'd2);
        send(32'hA000_0002, 1'b0, 8'd2);
        send(32'hA000_0003, 1'b0, 8'd3);
        chk("ovf_err", {63'd0, err}, 64'd1);
        chk("ovf_wc", {55'd0, word_count}, 64'd4);
        chk("ovf_host_ready", {63'd0, bus.host_ready}, 64'd0);
        repeat (3) tick();
        chk("ovf_hold_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        tick();
        chk("ovf_run_done", {63'd0, done}, 64'd1);
        chk("ovf_run_err", {63'd0, err}, 64'd1);
        chk("ovf_run_host_ready", {63'd0, bus.host_ready}, 64'd0);

        // Reload from RUN with a single word
        pulse_start();
        chk("reload_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("reload_err_cleared", {63'd0, err}, 64'd0);
        chk("reload_wc", {55'd0, word_count}, 64'd0);
        send(32'h0000_0013, 1'b1, 8'd0);
        chk("reload_done_low", {63'd0, done}, 64'd0);
        repeat (4) tick();
        chk("reload_done", {63'd0, done}, 64'd1);
        chk("reload_run_cpu_rst", {63'd0, cpu_rst}, 64'd0);

        // host_last at capacity takes precedence over overflow
        pulse_start();
        send(32'hB000_0000, 1'b0, 8'd0);
        send(32'hB000_0001, 1'b0, 8'd1);
        send(32'hB000_0002, 1'b0, 8'd2);
        send(32'hB000_0003, 1'b1, 8'd3);
        chk("cap_last_err", {63'd0, err}, 64'd0);
        chk("cap_last_wc", {55'd0, word_count}, 64'd4);
        repeat (4) tick();
        chk("cap_last_done", {63'd0, done}, 64'd1);

        // Reset in the middle of a load
        pulse_start();
        send(32'hC000_0000, 1'b0, 8'd0);
        send(32'hC000_0001, 1'b0, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_imem_en", {63'd0, bus.imem_en}, 64'd0);
        chk("midrst_imem_addr", {56'd0, bus.imem_addr}, 64'd0);
        chk("midrst_imem_data", {32'd0, bus.imem_data}, 64'd0);
        chk("midrst_wc", {55'd0, word_count}, 64'd0);
        chk("midrst_host_ready", {63'd0, bus.host_ready}, 64'd0);
        chk("midrst_load_active", {63'd0, load_active}, 64'd0);
        chk("midrst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        tick();
        pulse_start();
        send(32'hC000_0002, 1'b1, 8'd0);
        repeat (4) tick();
        chk("midrst_reload_done", {63'd0, done}, 64'd1);

`ifdef LOAD_CHECKSUM_EN
        // Checksum wraps modulo 2^32 and clears on start
        pulse_start();
        chk("checksum_cleared", {32'd0, checksum}, 64'd0);
        send(32'hFFFF_FFFF, 1'b0, 8'd0);
        send(32'h0000_0002, 1'b1, 8'd1);
        chk("checksum_wrap", {32'd0, checksum}, 64'h0000_0001);
        repeat (4) tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
